div_seq: RTL and testbench

//  Multi-cycle restoring divider sequencer for the execute stage (DIV/DIVU).
//  EX raises start_i with operands; the block iterates one quotient bit per

---
 rtl/div_seq.sv | 152 +++++++++++++++
 tb/tb_div_seq.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/div_seq.sv
// Multi-cycle restoring divider for DIV/DIVU: one quotient bit per cycle,
// returns {remainder, quotient} with a registered ready flag.
module div_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_FREE = 2'd0,
    S_ZERO = 2'd1,
    S_ON   = 2'd2,
    S_END  = 2'd3
  } state_t;

  state_t               r_state, w_state;
  logic [CW-1:0]        r_cnt, w_cnt;
  logic [2*WIDTH-1:0]   r_sr, w_sr;
  logic [WIDTH-1:0]     r_divisor, w_divisor;
  logic                 r_sign1, w_sign1;
  logic                 r_sign2, w_sign2;
  logic                 r_signed, w_signed;
  logic [2*WIDTH-1:0]   r_result, w_result;
  logic                 r_ready, w_ready;

  logic [WIDTH-1:0]     w_abs1, w_abs2;
  logic [WIDTH:0]       w_trial;
  logic [WIDTH-1:0]     w_quo, w_rem;

  // Operand magnitudes; only meaningful while sampling in FREE
  assign w_abs1 = (signed_div_i && opdata1_i[WIDTH-1]) ? WIDTH'(~opdata1_i + WIDTH'(1)) : opdata1_i;
  assign w_abs2 = (signed_div_i && opdata2_i[WIDTH-1]) ? WIDTH'(~opdata2_i + WIDTH'(1)) : opdata2_i;

  // Partial remainder with the next dividend bit shifted in, minus divisor
  assign w_trial = r_sr[2*WIDTH-1:WIDTH-1] - {1'b0, r_divisor};

  assign w_quo = (r_signed && (r_sign1 ^ r_sign2)) ? WIDTH'(~r_sr[WIDTH-1:0] + WIDTH'(1))
                                                   : r_sr[WIDTH-1:0];
  assign w_rem = (r_signed && r_sign1) ? WIDTH'(~r_sr[2*WIDTH-1:WIDTH] + WIDTH'(1))
                                       : r_sr[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_FREE;
      r_cnt     <= '0;
      r_sr      <= '0;
      r_divisor <= '0;
      r_sign1   <= 1'b0;
      r_sign2   <= 1'b0;
      r_signed  <= 1'b0;
      r_result  <= '0;
      r_ready   <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_cnt     <= w_cnt;
      r_sr      <= w_sr;
      r_divisor <= w_divisor;
      r_sign1   <= w_sign1;
      r_sign2   <= w_sign2;
      r_signed  <= w_signed;
      r_result  <= w_result;
      r_ready   <= w_ready;
    end
  end

  always_comb begin
    w_state   = r_state;
    w_cnt     = r_cnt;
    w_sr      = r_sr;
    w_divisor = r_divisor;
    w_sign1   = r_sign1;
    w_sign2   = r_sign2;
    w_signed  = r_signed;
    w_result  = r_result;
    w_ready   = r_ready;

    case (r_state)
      S_FREE: begin
        w_result = '0;
        w_ready  = 1'b0;
        if (start_i && !annul_i) begin
          if (opdata2_i == '0) begin
            w_state = S_ZERO;
          end else begin
            w_state   = S_ON;
            w_cnt     = '0;
            w_signed  = signed_div_i;
            w_sign1   = signed_div_i & opdata1_i[WIDTH-1];
            w_sign2   = signed_div_i & opdata2_i[WIDTH-1];
            w_sr      = {{WIDTH{1'b0}}, w_abs1};
            w_divisor = w_abs2;
          end
        end
      end

      S_ZERO: begin
        if (annul_i) begin
          w_state = S_FREE;
        end else begin
          w_state  = S_END;
          w_result = '0;
          w_ready  = 1'b1;
        end
      end

      S_ON: begin
        if (annul_i) begin
          w_state  = S_FREE;
          w_result = '0;
          w_ready  = 1'b0;
        end else if (r_cnt != CW'(WIDTH)) begin
          if (w_trial[WIDTH]) begin
            w_sr = {r_sr[2*WIDTH-2:0], 1'b0};
          end else begin
            w_sr = {w_trial[WIDTH-1:0], r_sr[WIDTH-2:0], 1'b1};
          end
          w_cnt = r_cnt + CW'(1);
        end else begin
          w_state  = S_END;
          w_result = {w_rem, w_quo};
          w_ready  = 1'b1;
        end
      end

      S_END: begin
        if (!start_i) begin
          w_state  = S_FREE;
          w_result = '0;
          w_ready  = 1'b0;
        end
      end

      default: begin
        w_state = S_FREE;
      end
    endcase
  end

  assign result_o = r_result;
  assign ready_o  = r_ready;

endmodule

// File: tb/tb_div_seq.sv
// Scoreboard bench for div_seq: directed corner cases plus random vectors
// against a magnitude-based reference divider.
module tb_div_seq;

  localparam int unsigned WIDTH = 32;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               signed_div_i = 1'b0;
  logic [WIDTH-1:0]   opdata1_i = '0;
  logic [WIDTH-1:0]   opdata2_i = '0;
  logic               start_i = 1'b0;
  logic               annul_i = 1'b0;
  logic [2*WIDTH-1:0] result_o;
  logic               ready_o;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [2*WIDTH-1:0] res;
    int                 lat;
  } exp_t;

  exp_t sb_q[$];

  div_seq #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: divide magnitudes with the language operators, then fix signs
  function automatic logic [2*WIDTH-1:0] ref_div(input logic s, input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] ma, mb, q, r;
    if (b == '0) return '0;
    ma = (s && a[WIDTH-1]) ? (~a + 1) : a;
    mb = (s && b[WIDTH-1]) ? (~b + 1) : b;
    q  = ma / mb;
    r  = ma % mb;
    if (s && (a[WIDTH-1] ^ b[WIDTH-1])) q = ~q + 1;
    if (s && a[WIDTH-1]) r = ~r + 1;
    return {r, q};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input bit push);
    exp_t e;
    signed_div_i = s;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    if (push) begin
      e.res = ref_div(s, a, b);
      e.lat = (b == '0) ? 2 : WIDTH + 2;
      sb_q.push_back(e);
    end
  endtask

  // mode 0: drop start after result; 1: hold one extra cycle first; 2: leave start high
  task automatic collect(input string tag, input int mode);
    exp_t e;
    int   cycles;
    cycles = 0;
    do begin
      tick();
      cycles++;
    end while (!ready_o && cycles < 60);
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 64'd1, 64'd0);
      return;
    end
    e = sb_q.pop_front();
    check({tag, "_lat"}, 64'(cycles), 64'(e.lat));
    check({tag, "_res"}, result_o, e.res);
    if (mode == 1) begin
      opdata1_i = ~opdata1_i;
      tick();
      check({tag, "_hold_rdy"}, 64'(ready_o), 64'd1);
      check({tag, "_hold_res"}, result_o, e.res);
    end
    if (mode != 2) begin
      start_i = 1'b0;
      tick();
      check({tag, "_drop_rdy"}, 64'(ready_o), 64'd0);
      check({tag, "_drop_res"}, result_o, 64'd0);
    end
  endtask

  initial begin
    int rdy_seen;
    logic s;
    logic [WIDTH-1:0] a, b;

    repeat (3) @(posedge clk);
    #1;
    check("reset_rdy", 64'(ready_o), 64'd0);
    check("reset_res", result_o, 64'd0);
    rst = 1'b1;
    tick();
    check("idle_rdy", 64'(ready_o), 64'd0);

    drive(1'b0, 32'd100, 32'd7, 1'b1);
    collect("udiv_100_7", 1);
    check("udiv_100_7_const", result_o, 64'd0);

    drive(1'b1, 32'hFFFFFFF9, 32'd2, 1'b1);
    collect("sdiv_m7_2", 0);

    drive(1'b0, 32'd5, 32'd0, 1'b1);
    collect("div_zero", 1);

    drive(1'b1, 32'h80000000, 32'hFFFFFFFF, 1'b1);
    collect("sdiv_ovf", 0);
    drive(1'b0, 32'hFFFFFFFF, 32'd1, 1'b1);
    collect("udiv_max_1", 0);

    // Annul while cnt==10, then a fresh divide with start held
    drive(1'b0, 32'd1000, 32'd3, 1'b0);
    rdy_seen = 0;
    repeat (11) begin
      tick();
      if (ready_o) rdy_seen++;
    end
    annul_i = 1'b1;
    tick();
    if (ready_o) rdy_seen++;
    check("annul_rdy_seen", 64'(rdy_seen), 64'd0);
    check("annul_res", result_o, 64'd0);
    annul_i = 1'b0;
    drive(1'b0, 32'd9, 32'd3, 1'b1);
    collect("after_annul", 0);

    // Async reset mid-ON
    drive(1'b0, 32'd100, 32'd7, 1'b0);
    repeat (5) tick();
    #2 rst = 1'b0;
    #1;
    check("rst_on_rdy", 64'(ready_o), 64'd0);
    check("rst_on_res", result_o, 64'd0);
    start_i = 1'b0;
    #2 rst = 1'b1;
    tick();

    // Async reset while a result is being held
    drive(1'b0, 32'd77, 32'd5, 1'b1);
    collect("pre_rst_end", 2);
    #2 rst = 1'b0;
    #1;
    check("rst_end_rdy", 64'(ready_o), 64'd0);
    check("rst_end_res", result_o, 64'd0);
    start_i = 1'b0;
    #2 rst = 1'b1;
    tick();

    drive(1'b0, 32'd100, 32'd7, 1'b1);
    collect("post_rst", 0);

    for (int i = 0; i < 200; i++) begin
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      case ($urandom_range(0, 7))
        0:       b = '0;
        1:       b = 32'd1;
        2:       b = 32'hFFFFFFFF;
        3:       b = 32'($urandom_range(1, 15));
        4:       begin b = $urandom; a = 32'h80000000; end
        default: b = $urandom;
      endcase
      drive(s, a, b, 1'b1);
      collect("rand", 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
